// File: rtl/net_output_stage.sv
// net_output_stage: turns the final-conv result into registered audio output samples.
// A rising edge on sample_clk opens a compute window; the next rising edge on in_v closes it
// and latches elements 0 and 1 of in_packed, each scaled by 4 and saturated, onto
// sample_out0/sample_out1.
// A second sample_clk rise before the result arrives sets the sticky overrun flag.
//
// Optional feature, macro NET_OUTPUT_DEBUG_EN:
//   defined   - each accept also presents the window latency on sample_out2 and the overrun
//               count on sample_out3 (both 15-bit, saturating).
//   undefined - sample_out2/sample_out3 are tied to 0 and the counters do not exist.
module net_output_stage #(
  parameter int unsigned W = 16,
  parameter int unsigned D = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_clk,
  input  logic [D*W-1:0]   in_packed,
  input  logic             in_v,
  output logic [W-1:0]     sample_out0,
  output logic [W-1:0]     sample_out1,
  output logic [W-1:0]     sample_out2,
  output logic [W-1:0]     sample_out3,
  output logic             busy,
  output logic             overrun
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e                state_q;
  logic                  sample_clk_q;
  logic                  in_v_q;
  logic                  sclk_rise;
  logic                  inv_rise;
  logic                  overrun_q;
  logic [W-1:0]          sample_out0_q;
  logic [W-1:0]          sample_out1_q;
  logic signed [W-1:0]   elem0;
  logic signed [W-1:0]   elem1;
  logic [W-1:0]          sat0;
  logic [W-1:0]          sat1;
  logic                  unused_in;

`ifdef NET_OUTPUT_DEBUG_EN
  localparam int unsigned CW = 15;
  localparam logic [CW-1:0] CntMax = {CW{1'b1}};

  logic [CW-1:0] lat_q;
  logic [CW-1:0] lat_inc;
  logic [CW-1:0] ovr_cnt_q;
  logic [CW-1:0] ovr_inc;
  logic [W-1:0]  sample_out2_q;
  logic [W-1:0]  sample_out3_q;
`endif

  // Scale by 4 at W+2 bits (cannot overflow there), then clamp to the W-bit signed range.
  function automatic logic [W-1:0] sat_shift(input logic signed [W-1:0] x);
    logic signed [W+1:0] wide;
    logic signed [W+1:0] max_v;
    logic signed [W+1:0] min_v;
    wide  = {x[W-1], x[W-1], x} << 2;
    max_v = {3'b000, {(W-1){1'b1}}};
    min_v = {3'b111, {(W-1){1'b0}}};
    if (wide > max_v) begin
      return max_v[W-1:0];
    end else if (wide < min_v) begin
      return min_v[W-1:0];
    end
    return wide[W-1:0];
  endfunction

  // Element k sits at bits [(D-k)*W-1 -: W]; only elements 0 and 1 feed the outputs.
  assign elem0     = in_packed[D*W-1 -: W];
  assign elem1     = in_packed[(D-1)*W-1 -: W];
  assign sat0      = sat_shift(elem0);
  assign sat1      = sat_shift(elem1);
  assign unused_in = ^in_packed;

  assign sclk_rise = sample_clk & ~sample_clk_q;
  assign inv_rise  = in_v & ~in_v_q;

`ifdef NET_OUTPUT_DEBUG_EN
  assign lat_inc = (lat_q == CntMax) ? lat_q : lat_q + 1'b1;
  assign ovr_inc = (ovr_cnt_q == CntMax) ? ovr_cnt_q : ovr_cnt_q + 1'b1;
`endif

  // Previous-cycle copies of the strobes for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sample_clk_q <= 1'b0;
      in_v_q       <= 1'b0;
    end else begin
      sample_clk_q <= sample_clk;
      in_v_q       <= in_v;
    end
  end

  // Window FSM together with its registered outputs and counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIdle;
      overrun_q     <= 1'b0;
      sample_out0_q <= '0;
      sample_out1_q <= '0;
`ifdef NET_OUTPUT_DEBUG_EN
      lat_q         <= '0;
      ovr_cnt_q     <= '0;
      sample_out2_q <= '0;
      sample_out3_q <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          // in_v edges seen while idle belong to no window and are dropped.
          if (sclk_rise) begin
            state_q <= StWait;
`ifdef NET_OUTPUT_DEBUG_EN
            lat_q   <= CW'(1);
`endif
          end
        end
        StWait: begin
`ifdef NET_OUTPUT_DEBUG_EN
          lat_q <= lat_inc;
`endif
          if (inv_rise) begin
            sample_out0_q <= sat0;
            sample_out1_q <= sat1;
`ifdef NET_OUTPUT_DEBUG_EN
            // Latency counts the accept cycle itself.
            sample_out2_q <= W'(lat_inc);
            sample_out3_q <= W'(ovr_cnt_q);
`endif
            if (sclk_rise) begin
              // Result and next strobe coincide: the new window starts at once.
`ifdef NET_OUTPUT_DEBUG_EN
              lat_q <= CW'(1);
`endif
            end else begin
              state_q <= StIdle;
            end
          end else if (sclk_rise) begin
            overrun_q <= 1'b1;
`ifdef NET_OUTPUT_DEBUG_EN
            ovr_cnt_q <= ovr_inc;
            lat_q     <= CW'(1);
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sample_out0 = sample_out0_q;
  assign sample_out1 = sample_out1_q;
`ifdef NET_OUTPUT_DEBUG_EN
  assign sample_out2 = sample_out2_q;
  assign sample_out3 = sample_out3_q;
`else
  assign sample_out2 = '0;
  assign sample_out3 = '0;
`endif
  assign busy        = (state_q == StWait);
  assign overrun     = overrun_q;

endmodule

// File: doc/net_output_stage.md
NET_OUTPUT_STAGE -- requirements
Module: net_output_stage

Interface
REQ-001 Parameter W, default 16, width of each signed sample element.
REQ-002 Parameter D, default 8, number of W-bit elements in the packed input.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; one clock; reset is synchronous and active-low (rst low at a clk rising edge resets the block).
REQ-005 sample_clk  input  1  audio sample strobe; each rising edge opens one compute window.
REQ-006 in_packed  input  D*W  signed final-conv output; element k occupies bits [(D-k)*W-1:(D-k-1)*W], so element 0 is at the MSBs.
REQ-007 in_v  input  1  final-conv valid level; its 0->1 transition marks a fresh result.
REQ-008 sample_out0..sample_out3  output  W each  signed registered output samples.
REQ-009 busy  output  1  high while a compute window is open (state WAIT).
REQ-010 overrun  output  1  sticky flag, set when a window is missed.

Function
REQ-011 The block SHALL register sample_clk and in_v once each cycle and SHALL use registered-vs-current comparison for rising-edge detection; there is no further synchronisation.
REQ-012 The state machine SHALL have two states: IDLE and WAIT.
REQ-013 IDLE: on a sample_clk rise, go to WAIT and clear the latency counter to 1; otherwise stay in IDLE.
REQ-014 WAIT: the latency counter SHALL increment each cycle, saturating at 0x7FFF.
REQ-015 WAIT: an in_v rise SHALL accept the result, update the outputs, and return to IDLE; an in_v level that was already high on entry SHALL be ignored.
REQ-016 Accept: sample_out0 = sat(element 0 <<< 2) and sample_out1 = sat(element 1 <<< 2), where sat clamps to [-32768, 32767].
REQ-017 Outputs SHALL become visible on the cycle after the accept cycle, and SHALL hold their values at all other times.
REQ-018 A sample_clk rise while in WAIT without an in_v rise is an overrun: set overrun, increment the overrun count (saturating at 0x7FFF), restart the latency counter at 1, stay in WAIT, and leave the outputs unchanged.
REQ-019 A sample_clk rise and an in_v rise in the same WAIT cycle: accept the result per REQ-016, count no overrun, then stay in WAIT with the latency counter restarted at 1.
REQ-020 busy SHALL equal (state == WAIT).
REQ-021 Arithmetic: the shift SHALL be done at W+2 bits before saturation, with no wrap-around at any point.

Reset
REQ-022 In reset: state=IDLE; all sample_out*=0; overrun=0; latency counter=0; overrun count=0; edge registers=0.
REQ-023 A reset during WAIT SHALL abandon the window with no output update; the first sample_clk rise after reset release SHALL open a new window normally.
REQ-024 The overrun flag SHALL be cleared only by reset.

Configuration
REQ-025 Macro NET_OUTPUT_DEBUG_EN defined: on each accept, sample_out2 = latency counter value and sample_out3 = overrun count.
REQ-026 Macro NET_OUTPUT_DEBUG_EN undefined: sample_out2 and sample_out3 SHALL be constant 0, and the latency counter and overrun-count registers SHALL be removed; the overrun flag and FSM are unaffected.

Verification
REQ-027 Reset, then sample_clk rise, then element0=0x0100 and element1=0xFF00 with an in_v rise 10 cycles after the edge -> sample_out0=0x0400, sample_out1=0xFC00; with debug, sample_out2=11; busy low afterwards.
REQ-028 element0=0x3000, element1=0xC000 -> sample_out0=0x7FFF, sample_out1=0x8000 (saturation).
REQ-029 Two sample_clk rises with no in_v rise between them -> overrun=1; outputs unchanged; with debug, sample_out3=1 at the next accept.
REQ-030 in_v held high from the previous window through a new sample_clk rise -> no accept until in_v falls and rises again.
REQ-031 sample_clk rise and in_v rise in the same WAIT cycle -> result accepted, overrun stays 0, busy stays 1.
REQ-032 rst low for 1 cycle in WAIT -> all outputs 0 and busy 0; the next edge plus in_v rise produces correct outputs.
